// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory req/gnt/rvalid bus, execute redirect and
// the valid/ready instruction hand-off to decode. master = fetch, slave = environment.
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// RISC-V instruction fetch: owns the PC, keeps at most one memory request in flight,
// hands instructions to decode and squashes in-flight fetches on redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] BOOT_PC  = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_pc4_q, inst_pc4_d;
    logic [31:0] redirect_tgt;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign redirect_tgt = word_align(bus.redirect_pc);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_pc4_d   = inst_pc4_q;

        if (rst) begin
            // A request still owed a response must have that response swallowed.
            state_d      = (state_q == S_WAIT || state_q == S_DROP) ? S_DROP : S_REQ;
            pc_d         = BOOT_PC;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            inst_pc_d    = BOOT_PC;
            inst_pc4_d   = pc_plus4(BOOT_PC);
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.redirect_valid) begin
                        pc_d    = redirect_tgt;
                        state_d = bus.imem_gnt ? S_DROP : S_REQ;
                    end else if (bus.imem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_valid) begin
                        pc_d    = redirect_tgt;
                        state_d = bus.imem_rvalid ? S_REQ : S_DROP;
                    end else if (bus.imem_rvalid) begin
                        inst_d       = bus.imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_pc4_d   = pc_plus4(pc_q);
                        pc_d         = pc_plus4(pc_q);
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (bus.redirect_valid) begin
                        pc_d = redirect_tgt;
                    end
                    // The squashed response retires the outstanding request even if a
                    // redirect lands on the same cycle; waiting on would never end.
                    if (bus.imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect_valid) begin
                        pc_d         = redirect_tgt;
                        inst_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end else if (bus.inst_ready) begin
                        inst_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        inst_valid_q <= inst_valid_d;
        inst_q       <= inst_d;
        inst_pc_q    <= inst_pc_d;
        inst_pc4_q   <= inst_pc4_d;
    end

    assign bus.imem_req   = (state_q == S_REQ) && !rst;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_pc4   = inst_pc4_q;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage of the RISC-V core. It sits directly upstream of decode and immediate generation.
- Owns the program counter and issues word requests to instruction memory over a req/gnt + rvalid handshake.
- Presents the fetched instruction, its PC and PC+4 to decode with a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute and squashes any in-flight fetch.

Parameters:
RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 00

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word-aligned fetch address, equals pc while imem_req=1
imem_gnt  input  1  memory accepted request this cycle (qualified by imem_req)
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction word
redirect_valid  input  1  execute requests PC change
redirect_pc  input  32  redirect target; bits [1:0] forced to 00 internally
inst_valid  output  1  inst/inst_pc/inst_pc4 valid for decode
inst_ready  input  1  decode accepts instruction
inst  output  32  fetched instruction word
inst_pc  output  32  address of inst
inst_pc4  output  32  inst_pc + 4, modulo 2^32

Behaviour:
States: REQ, WAIT, HOLD, DROP. The internal pc register is separate from inst_pc.

Reset (rst=1 at edge):
- state=REQ, pc=RESET_PC.
- inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, inst_pc4=RESET_PC+4.
- imem_req=0 while rst=1.
- Reset mid-transaction abandons it. Any rvalid arriving after reset for a pre-reset request is discarded in DROP. Reset enters DROP instead of REQ only if a request was outstanding (state WAIT or DROP at reset).

REQ:
- imem_req=1, imem_addr=pc; both held stable until gnt.
- imem_gnt=1 -> WAIT.
- redirect_valid=1 without gnt: pc<=target; stay REQ (address changes next cycle, legal since not granted).
- redirect_valid=1 with gnt same cycle: pc<=target -> DROP.

WAIT:
- imem_req=0.
- imem_rvalid=1, no redirect: inst<=imem_rdata, inst_pc<=pc, inst_pc4<=pc+4, pc<=pc+4, inst_valid<=1 -> HOLD.
- redirect_valid=1 and rvalid=1: data discarded, pc<=target -> REQ.
- redirect_valid=1 and rvalid=0: pc<=target -> DROP.

DROP:
- imem_req=0, inst_valid=0.
- Wait for imem_rvalid, discard data -> REQ.
- A further redirect here updates pc and stays in DROP.

HOLD:
- inst_valid=1; inst/inst_pc/inst_pc4 stable while inst_ready=0 (no change while stalled).
- inst_valid & inst_ready -> inst_valid<=0 -> REQ.
- redirect_valid=1: pc<=target, inst_valid<=0 -> REQ, regardless of inst_ready.

General rules:
- imem_rvalid in REQ or HOLD is unsolicited and ignored.
- redirect has priority over every other event in every state.
- At most one outstanding memory request.
- Arithmetic: pc+4 is 32-bit and wraps (32'hFFFF_FFFC -> 0).
- Latency: with gnt in the request cycle and rvalid the next cycle, inst_valid rises 2 cycles after REQ entry. Sustained throughput with inst_ready tied high is 1 instruction per 3 cycles.

Test Plan:
1. Sequential fetch: release rst, gnt=1 always, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000, inst_ready=1 -> imem_addr sequence 0,4,8. inst_pc 0,4,8 with matching inst. inst_pc4 = inst_pc+4.
2. Decode stall: inst_ready=0 for 5 cycles in HOLD -> inst_valid=1 and inst/inst_pc unchanged all 5 cycles, imem_req=0. Release -> next request at inst_pc+4.
3. Redirect in WAIT (no rvalid), redirect_pc=32'h0000_0103 -> DROP. Next rvalid data is never presented. Next imem_addr=32'h0000_0100.
4. Redirect coincident with gnt for addr 8, target 32'h40 -> response for 8 discarded. Following request addr 32'h40. First presented inst_pc=32'h40.
5. Wrap: RESET_PC=32'hFFFF_FFFC -> first inst_pc4=0. Second fetch addr 0.
6. Reset mid-WAIT: assert rst for 1 cycle, then deliver stale rvalid -> stale data dropped. Next imem_addr=RESET_PC. inst_valid=0 until its response arrives.
